// File: rtl/periph_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : periph_bus_initiator
// Description : Single-outstanding initiator that bridges a valid/ready
//               load/store request/response pair onto the 11-bit address,
//               32-bit data peripheral bus.
//               Optional feature macro: PBI_RANGE_CHECK_EN (rejects
//               addresses above MAX_ADDR with rsp_err and no bus strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module periph_bus_initiator #(
    parameter int          RD_LAT   = 1,
    parameter logic [10:0] MAX_ADDR = 11'h7FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [10:0] bus_address,
    output logic [31:0] bus_data,
    output logic        bus_rden,
    output logic        bus_wren,
    output logic        bus_clken,
    input  logic [31:0] bus_q
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        addr_q,  addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q,    we_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        rdata_q, rdata_d;
`ifdef PBI_RANGE_CHECK_EN
    logic               err_q,   err_d;
`else
    // MAX_ADDR has no consumer when the range check is not built.
    logic               unused_max_addr;
    assign unused_max_addr = ^MAX_ADDR;
`endif

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
`ifdef PBI_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef PBI_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: accept, one strobe cycle, read wait, response hold.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef PBI_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef PBI_RANGE_CHECK_EN
                    if (req_addr > MAX_ADDR) begin
                        // Bus-visible address/data are left untouched so they
                        // keep showing the last issued transfer.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        we_d    = req_we;
                        err_d   = 1'b0;
                        state_d = ST_STROBE;
                    end
`else
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    state_d = ST_STROBE;
`endif
                end
            end
            ST_STROBE: begin
                if (we_q) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = bus_q;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode the state register only, so they fall with async reset.
    assign bus_clken   = (state_q == ST_STROBE);
    assign bus_wren    = bus_clken &  we_q;
    assign bus_rden    = bus_clken & ~we_q;
    assign bus_address = addr_q;
    assign bus_data    = wdata_q;

    // Gating with rst_n keeps ready low while reset is held even though the
    // state register already sits in IDLE.
    assign req_ready   = (state_q == ST_IDLE) & rst_n;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
`ifdef PBI_RANGE_CHECK_EN
    assign rsp_err     = err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_periph_bus_initiator
// Description : Directed bench for periph_bus_initiator. Unit 0 uses
//               RD_LAT=1, unit 1 uses RD_LAT=3; each has a small peripheral
//               model (16-word memory with registered q).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_bus_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        req_valid, req_we, rsp_ready;
    logic [1:0][10:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    wire  [1:0]        req_ready, rsp_valid, rsp_err, bus_rden, bus_wren, bus_clken;
    wire  [1:0][31:0]  rsp_rdata, bus_data;
    wire  [1:0][10:0]  bus_address;
    wire  [1:0][7:0]   rd_cnt, wr_cnt;
    wire  [1:0]        mem0_b0;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_unit
        logic [31:0] mem [16];
        logic [31:0] q    = '0;
        logic [7:0]  n_rd = '0;
        logic [7:0]  n_wr = '0;

        periph_bus_initiator #(
            .RD_LAT   ((g == 0) ? 1 : 3),
            .MAX_ADDR (11'h0FF)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .req_we      (req_we[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .rsp_err     (rsp_err[g]),
            .bus_address (bus_address[g]),
            .bus_data    (bus_data[g]),
            .bus_rden    (bus_rden[g]),
            .bus_wren    (bus_wren[g]),
            .bus_clken   (bus_clken[g]),
            .bus_q       (q)
        );

        // Peripheral model: write on wren, registered read on rden.
        always @(posedge clk) begin
            if (bus_clken[g] && bus_wren[g]) begin
                mem[bus_address[g][3:0]] <= bus_data[g];
                n_wr <= n_wr + 8'd1;
            end
            if (bus_clken[g] && bus_rden[g]) begin
                q    <= mem[bus_address[g][3:0]];
                n_rd <= n_rd + 8'd1;
            end
        end

        assign rd_cnt[g]  = n_rd;
        assign wr_cnt[g]  = n_wr;
        assign mem0_b0[g] = mem[0][0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request on unit u; returns at the first sample showing rsp_valid.
    task automatic txn(input int u, input bit we, input logic [10:0] a,
                       input logic [31:0] d, input int exp_k, input logic [31:0] exp_rd);
        int       k;
        bit       seen;
        logic [7:0] r0, w0;
        @(negedge clk);
        check("ready_before_req", req_ready[u], 1);
        r0 = rd_cnt[u];
        w0 = wr_cnt[u];
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = a;
        req_wdata[u] = d;
        k    = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            req_valid[u] = 1'b0;
            if (k == 1) begin
                check("strobe_clken", bus_clken[u], 1);
                check("strobe_wren",  bus_wren[u], we);
                check("strobe_rden",  bus_rden[u], !we);
                check("strobe_addr",  bus_address[u], a);
                if (we) check("strobe_data", bus_data[u], d);
            end else if (rsp_valid[u]) begin
                seen = 1;
            end else begin
                check("wait_no_strobe", bus_clken[u], 0);
            end
        end
        check("rsp_latency",   k, exp_k);
        check("rsp_rdata",     rsp_rdata[u], exp_rd);
        check("rsp_err",       rsp_err[u], 0);
        check("rsp_not_ready", req_ready[u], 0);
        check("addr_hold",     bus_address[u], a);
        check("rd_strobes",    rd_cnt[u] - r0, we ? 0 : 1);
        check("wr_strobes",    wr_cnt[u] - w0, we ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r0, w0;
        int hits;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b11;

        // Reset held with requests pending: everything quiet.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready",  req_ready, 0);
            check("rst_strobe", {bus_clken, bus_rden, bus_wren}, 0);
            check("rst_rsp",    {rsp_valid, rsp_err}, 0);
        end
        check("rst_rdata", rsp_rdata[0], 0);
        check("rst_addr",  bus_address[1], 0);
        check("rst_data",  bus_data[0], 0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        #1;
        check("ready_after_release", req_ready, 2'b11);
        check("no_strobe_in_reset",  rd_cnt[0] + wr_cnt[0], 0);

        // Write then read back with RD_LAT=1.
        txn(0, 1'b1, 11'h000, 32'h1, 2, 32'h0);
        check("periph_bit0", mem0_b0[0], 1);
        txn(0, 1'b0, 11'h000, 32'h0, 3, 32'h1);

        // Response backpressure plus a request colliding with the handshake.
        txn(0, 1'b1, 11'h003, 32'hA5A5_5A5A, 2, 32'h0);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        txn(0, 1'b0, 11'h003, 32'h0, 3, 32'hA5A5_5A5A);
        r0 = rd_cnt[0];
        w0 = wr_cnt[0];
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 11'h003;
        req_wdata[0] = 32'h0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", rsp_valid[0], 1);
            check("stall_rdata", rsp_rdata[0], 32'hA5A5_5A5A);
            check("stall_ready", req_ready[0], 0);
            check("stall_clken", bus_clken[0], 0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("post_hs_valid", rsp_valid[0], 0);
        check("post_hs_ready", req_ready[0], 1);
        check("post_hs_clken", bus_clken[0], 0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("late_req_wren", bus_wren[0], 1);
        check("late_req_data", bus_data[0], 32'h0);
        @(negedge clk);
        check("late_rsp_valid", rsp_valid[0], 1);
        check("late_rsp_rdata", rsp_rdata[0], 32'h0);
        check("stall_rd_strobes", rd_cnt[0] - r0, 0);
        check("stall_wr_strobes", wr_cnt[0] - w0, 1);
        txn(0, 1'b0, 11'h003, 32'h0, 3, 32'h0);

        // Top-of-range address.
`ifdef PBI_RANGE_CHECK_EN
        @(negedge clk);
        r0 = rd_cnt[0];
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 11'h7FF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("range_valid", rsp_valid[0], 1);
        check("range_err",   rsp_err[0], 1);
        check("range_rdata", rsp_rdata[0], 0);
        check("range_clken", bus_clken[0], 0);
        check("range_rd_strobes", rd_cnt[0] - r0, 0);
`else
        txn(0, 1'b1, 11'h7FF, 32'h1234_5678, 2, 32'h0);
        txn(0, 1'b0, 11'h7FF, 32'h0, 3, 32'h1234_5678);
`endif

        // RD_LAT=3 unit.
        txn(1, 1'b1, 11'h005, 32'hDEAD_BEEF, 2, 32'h0);
        txn(1, 1'b0, 11'h005, 32'h0, 5, 32'hDEAD_BEEF);

        // Reset while a read waits: the transaction vanishes.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 11'h005;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("abort_strobe", bus_rden[1], 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", rsp_valid[1], 0);
        check("abort_ready", req_ready[1], 0);
        check("abort_rdata", rsp_rdata[1], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hits  = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1]) hits++;
        end
        check("abort_no_rsp", hits, 0);
        txn(1, 1'b0, 11'h005, 32'h0, 5, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/periph_bus_initiator.md
# periph_bus_initiator

Single-outstanding initiator for the 11-bit-address, 32-bit-data peripheral bus. It drives `address`/`data`/`rden`/`wren`/`clken` toward memory-mapped peripherals and collects their registered `q` read data. It sits between the core's load/store path (valid/ready request and response channels) and the peripheral bus, and converts each accepted request into exactly one bus strobe cycle and exactly one response.

## Interface
- `RD_LAT`, default 1: number of cycles after the strobe cycle before `bus_q` is sampled. Legal range is 1..4.
- `MAX_ADDR`, default 11'h7FF: highest legal address. Used only when `PBI_RANGE_CHECK_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: initiator can accept a request.
- `req_addr` in 11: word address.
- `req_wdata` in 32: write data.
- `req_we` in 1: 1 = write, 0 = read.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_err` out 1: error flag for the response.
- `bus_address` out 11: peripheral address.
- `bus_data` out 32: peripheral write data.
- `bus_rden` out 1: read strobe.
- `bus_wren` out 1: write strobe.
- `bus_clken` out 1: peripheral clock enable.
- `bus_q` in 32: peripheral registered read data.

## Operation
- States are IDLE, STROBE, WAIT and RESP, held in a state register.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready` at an edge, latch `req_addr`, `req_wdata` and `req_we`, then go to STROBE.
- **STROBE** lasts exactly one cycle.
  - `bus_clken` = 1; `bus_wren` = latched `we`; `bus_rden` = !latched `we`.
  - `bus_address` and `bus_data` carry the latched values.
  - A write goes next to RESP.
  - A read loads the wait counter with `RD_LAT` and goes to WAIT.
- **WAIT** (reads only)
  - The counter decrements every cycle.
  - In the cycle where the counter equals 1, `bus_q` is captured into `rsp_rdata` at the edge, and the state moves to RESP.
  - The counter is `$clog2(RD_LAT+1)` bits wide and never wraps.
- **RESP**
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are stable while `rsp_valid` is high.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - `rsp_ready` held low stalls indefinitely; no new request is accepted during the stall.
- Writes return `rsp_rdata` = 32'h0. `rsp_rdata` is also cleared on write completion.
- Bus outputs:
  - `bus_rden`, `bus_wren` and `bus_clken` are 1 only in STROBE and 0 in every other state.
  - `bus_address` and `bus_data` hold their last issued values outside STROBE.
  - All bus outputs come from registers or from decode of the state register only. There is no combinational path from `req_*` to `bus_*`.
- `req_ready` is 1 only in IDLE and is a function of state alone. It does not depend on `req_valid`.
- Exactly one transaction is outstanding at a time. There is no request buffering.

## Timing
- **Reset values:** state = IDLE; `req_ready` = 0 while `rst_n` is low and 1 from the first cycle after release; `rsp_valid`, `rsp_err`, `bus_rden`, `bus_wren` and `bus_clken` = 0; `rsp_rdata`, `bus_address` and `bus_data` = 0.
- **Accept timing:** a request accepted at edge E puts STROBE in the cycle after E.
- **Write latency:** `rsp_valid` rises at edge E+2.
- **Read latency:** `rsp_valid` rises at edge E+2+`RD_LAT`.
- **Minimum request spacing:** reads take 3+`RD_LAT` cycles and writes take 3 cycles, with `rsp_ready` held at 1.
- **Peripheral contract:** the peripheral updates `q` on the edge ending STROBE when `bus_clken && bus_rden`. With `RD_LAT`=1, `bus_q` is sampled one cycle later.
- **Reset mid-operation:** the transaction is aborted with no response. Strobes drop asynchronously with `rst_n`. Any pending `rsp_valid` is discarded.
- **Simultaneous events:** a `req_valid` in the same cycle as the RESP handshake is not accepted. It is accepted in the following IDLE cycle.

## Configuration
- `PBI_RANGE_CHECK_EN` defined:
  - In IDLE, a request with `req_addr > MAX_ADDR` skips STROBE and WAIT.
  - It goes to RESP in the next cycle with `rsp_err` = 1 and `rsp_rdata` = 0.
  - No bus strobe is asserted for that request.
  - Legal addresses behave exactly as without the macro.
- `PBI_RANGE_CHECK_EN` not defined:
  - No address compare is built; `MAX_ADDR` is ignored.
  - `rsp_err` is tied to 0.
  - Every request is issued on the bus.

## Test plan
- **Reset:** hold `rst_n` low for 3 cycles with `req_valid`=1 → all outputs 0 and no strobe; `req_ready`=1 on the first cycle after release.
- **Write:** write addr 11'h000, data 32'h1, `RD_LAT`=1 → one cycle with `bus_wren`=1, `bus_clken`=1, `bus_address`=0 and `bus_data`=1; the peripheral's port bit 0 reads 1; `rsp_valid` at E+2 with `rsp_rdata`=0.
- **Read back:** read addr 11'h000 after the write → `bus_rden` pulses for exactly 1 cycle; `rsp_valid` at E+3 with `rsp_rdata`=32'h1. Repeat with `RD_LAT`=3 → response at E+5.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles during RESP → `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0, and there are no bus strobes; release → back to IDLE in the next cycle.
- **Reset during WAIT:** assert `rst_n` low during WAIT with `RD_LAT`=3 → no response ever appears; the next read completes normally with the correct data.
- **Range check:** with `PBI_RANGE_CHECK_EN` defined and `MAX_ADDR`=11'h0FF, read addr 11'h7FF → no `bus_rden`/`bus_clken`; `rsp_err`=1 and `rsp_rdata`=0 at E+1. Without the macro → a normal bus read and `rsp_err`=0.
